// File: rtl/button_pkg.sv
// Shared types and widths for the push-button conditioning path.
package button_pkg;

  // Press/hold/release tracking states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } btn_state_e;

  // Width of the accepted-press counter shown on LEDs and debug.
  localparam int PRESS_COUNT_W = 8;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous level.
// Also usable for reset-request synchronisation at top level.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("sync_chain: STAGES must be in 2..4");
  end

  logic [STAGES-1:0] ff;

  // Shift the input through the flop chain; reset clears every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Raw push-button -> synchronised, debounced level plus single-cycle
// press / release / long-press events and an 8-bit press counter.
//
// Handshake note: there is no valid/ready handshake here. Every pulse
// output is a registered one-cycle strobe that the consumer must sample
// in the cycle it is high; nothing is held or back-pressured, and at
// most one of the three strobes is high in any cycle.
module button_conditioner
  import button_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int ACTIVE_LOW        = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     btn_raw,
  output logic                     btn_level,
  output logic                     press_pulse,
  output logic                     release_pulse,
  output logic                     long_press_pulse,
  output logic [PRESS_COUNT_W-1:0] press_count
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("button_conditioner: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("button_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (LONG_PRESS_CYCLES < 1) begin : g_bad_long
    $error("button_conditioner: LONG_PRESS_CYCLES must be >= 1");
  end

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic              btn_in;
  logic              sync_out;
  logic [DEB_W-1:0]  deb_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              accept;
  logic              rise;
  logic              fall;
  btn_state_e        state;

  // Normalise polarity so 1 always means pressed from here on.
  assign btn_in = btn_raw ^ (ACTIVE_LOW != 0);

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (sync_out)
  );

  // A level change is accepted on the cycle the mismatch run completes.
  assign accept = (sync_out != btn_level) && (deb_cnt == DEB_LAST);
  assign rise   = accept & sync_out;
  assign fall   = accept & ~sync_out;

  // Debounce: count consecutive mismatch cycles, any agreement restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt   <= '0;
      btn_level <= 1'b0;
    end else if (sync_out == btn_level) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      btn_level <= sync_out;
      deb_cnt   <= '0;
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  // Press/hold/release FSM with registered strobes and press counter;
  // strobes land on the same edge that moves btn_level.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      hold_cnt         <= '0;
      press_count      <= '0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
    end else begin
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state       <= PRESSED;
            press_pulse <= 1'b1;
            press_count <= press_count + PRESS_COUNT_W'(1);
            hold_cnt    <= '0;
          end
        end
        PRESSED: begin
          // A release on the threshold cycle takes priority over long press.
          if (fall) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
          end else if (hold_cnt == HOLD_LAST) begin
            state            <= HELD;
            long_press_pulse <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        HELD: begin
          if (fall) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Conditions one raw push-button input into clean, single-cycle control events for the initiator trigger and reset logic of the serial-bus system. It sits directly upstream of the initiator `trigger` input and replaces ad-hoc two-flop synchronisers at top level. Stages are a synchroniser chain, a debounce filter, a press/hold/release state machine and an 8-bit press counter for LED and debug visibility.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops; legal range 2..4.
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change; minimum 1 (10 ms at 50 MHz).
LONG_PRESS_CYCLES, 50000000, cycles the debounced level must stay pressed before long_press_pulse fires; minimum 1.
ACTIVE_LOW, 0, 1 = raw button reads 0 when pressed; the input is inverted before synchronisation.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
btn_raw  input  1  asynchronous raw button pin
btn_level  output  1  debounced level, 1 = pressed
press_pulse  output  1  one-cycle pulse on accepted press
release_pulse  output  1  one-cycle pulse on accepted release
long_press_pulse  output  1  one-cycle pulse when a press reaches LONG_PRESS_CYCLES
press_count  output  8  number of accepted presses, wraps modulo 256

Behaviour:
- Reset:
  - Single clock clk; reset is synchronous and active-high on rst; every flop, including the synchroniser chain, is cleared on rst.
  - All outputs are 0, the state machine is in IDLE, and all counters are 0.
  - The synchroniser chain resets to the "not pressed" value, so releasing reset while the button is held produces a press after the normal latency.
- Input stage:
  - btn_raw is XORed with ACTIVE_LOW, then passed through SYNC_STAGES flops to give sync_out.
- Debounce:
  - deb_cnt has width $clog2(DEBOUNCE_CYCLES+1).
  - Any cycle where sync_out == btn_level clears deb_cnt.
  - On a mismatch cycle, if deb_cnt == DEBOUNCE_CYCLES-1, btn_level <= sync_out and deb_cnt <= 0; otherwise deb_cnt increments.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes btn_level.
- Latency:
  - A clean raw change that is held steady updates btn_level SYNC_STAGES + DEBOUNCE_CYCLES edges after it is first sampled.
  - Pulses are registered at the same edge that updates btn_level, so press_pulse/release_pulse rise in the same cycle as the btn_level edge.
- State machine (states in button_pkg):
  - IDLE: on accepted rise -> PRESSED; press_pulse = 1; press_count += 1; hold_cnt <= 0.
  - PRESSED: hold_cnt increments each cycle.
    - On accepted fall -> IDLE with release_pulse = 1.
    - Else if hold_cnt == LONG_PRESS_CYCLES-1 -> HELD with long_press_pulse = 1.
    - If the fall and the threshold coincide in the same cycle, the fall wins: release only, no long pulse.
  - HELD: hold_cnt frozen; on accepted fall -> IDLE with release_pulse = 1.
  - long_press_pulse therefore fires exactly LONG_PRESS_CYCLES cycles after press_pulse, at most once per press.
- Pulse and counter rules:
  - Pulses are 1 only for one cycle and are otherwise 0; at most one of the three is 1 in any cycle.
  - press_count wraps 255 -> 0 with no saturation or flag.
  - hold_cnt has width $clog2(LONG_PRESS_CYCLES+1).
- Reset mid-press: rst asserted in any state forces IDLE and clears outputs the next edge; no release_pulse is generated for the aborted press.
- Parameter checks: elaboration-time assertions reject SYNC_STAGES < 2, DEBOUNCE_CYCLES < 1 and LONG_PRESS_CYCLES < 1.

Decomposition:
- button_pkg holds:
  - btn_state_e enum {IDLE, PRESSED, HELD} (2-bit);
  - localparam PRESS_COUNT_W = 8.
- One sub-module, sync_chain (parameter STAGES, ports clk, rst, d, q). It is reusable for btn_reset synchronisation at top level.
- Debounce, FSM and counters stay in button_conditioner.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, ACTIVE_LOW=0 unless noted.
- Reset: hold rst 3 cycles with btn_raw=1, release at edge 0 -> all outputs 0 during reset; btn_level and press_pulse rise at edge 6; press_count=1.
- Glitch rejection: btn_raw=1 for 3 cycles, then 0 -> btn_level, press_pulse and press_count never change.
- Short press: btn_raw high 8 cycles -> press_pulse one cycle at latency 6; release_pulse one cycle 8 cycles later; long_press_pulse never asserts.
- Long press: btn_raw held 20 cycles -> long_press_pulse exactly 10 cycles after press_pulse, once; state HELD; release_pulse on release; no second long pulse.
- Coincident fall/threshold: time the release so the accepted fall lands on the threshold cycle (hold_cnt == 9) -> release_pulse only, long_press_pulse stays 0.
- Wrap and mid-press reset:
  - 256 clean presses -> press_count returns to 0.
  - Then press, assert rst while PRESSED -> outputs 0 next edge with no release_pulse.
  - Repeat the first press with ACTIVE_LOW=1 driving btn_raw=0 -> press_pulse at latency 6.
